// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//   Bundles the pipeline-side signals of the hazard/stall controller.
//
//   IR_D, IR_E, IR_M : instructions currently in ID, EX and MEM (pipeline -> ctrl)
//   stall            : hold PC and IF/ID this cycle             (ctrl -> pipeline)
//   flush_E          : load NOP into ID/EX this cycle           (ctrl -> pipeline)
//   md_start         : one-cycle start pulse to the MDU         (ctrl -> MDU)
//   md_op            : MDU op 0 mult, 1 multu, 2 div, 3 divu    (ctrl -> MDU)
//   md_busy          : MDU countdown nonzero                    (ctrl -> pipeline)
//   stall_cycles     : saturating count of stalled cycles       (ctrl -> perf)
//
//   master : the pipeline side, drives the instruction registers.
//   slave  : the hazard controller.
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if;
    logic [31:0] IR_D;
    logic [31:0] IR_E;
    logic [31:0] IR_M;
    logic        stall;
    logic        flush_E;
    logic        md_start;
    logic [1:0]  md_op;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output IR_D, IR_E, IR_M,
        input  stall, flush_E, md_start, md_op, md_busy, stall_cycles
    );

    modport slave (
        input  IR_D, IR_E, IR_M,
        output stall, flush_E, md_start, md_op, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Hazard controller for the 5-stage MIPS pipeline. Detects dependencies that
//   the bypass network cannot cover (load-use, branch/jr on a not-yet-available
//   result, MDU results still in flight), freezes PC and IF/ID and bubbles
//   ID/EX. Also sequences the multi-cycle multiply/divide unit and keeps a
//   saturating stall-cycle performance counter.
//
// Ports
//   clk    : pipeline clock, rising edge
//   reset  : synchronous, active-high reset
//   bus    : hazard_stall_ctrl_if.slave (IR_D/IR_E/IR_M in; stall, flush_E,
//            md_start, md_op, md_busy, stall_cycles out)
//
// Parameters
//   MULT_CYCLES : busy cycles after a mult/multu start (1..15)
//   DIV_CYCLES  : busy cycles after a div/divu start (1..15)
//   CNT_W       : width of the MDU countdown; holds max(MULT_CYCLES, DIV_CYCLES)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_stall_ctrl_if.slave   bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Instruction classes relevant to hazard detection.
    typedef struct packed {
        logic ld;
        logic st;
        logic beq;
        logic jr;
        logic cal_i;
        logic md_st;   // mult/multu/div/divu
        logic md_rd;   // mfhi/mflo
        logic md_wr;   // mthi/mtlo
        logic cal_r;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        logic       r;
        dec_t       d;
        op      = ir[31:26];
        fn      = ir[5:0];
        r       = (op == OP_RTYPE);
        d       = '0;
        d.ld    = (op == OP_LW);
        d.st    = (op == OP_SW);
        d.beq   = (op == OP_BEQ);
        d.jr    = r && (fn == FN_JR);
        d.cal_i = (op == OP_ORI) || (op == OP_LUI);
        d.md_st = r && (fn[5:2] == 4'b0110);
        d.md_rd = r && ((fn == 6'b010000) || (fn == 6'b010010));
        d.md_wr = r && ((fn == 6'b010001) || (fn == 6'b010011));
        // 0100xx covers all four hi/lo moves; func 0 is sll/NOP and is ignored.
        d.cal_r = r && (fn != 6'b000000) && (fn != FN_JR) &&
                  (fn[5:2] != 4'b0110) && (fn[5:2] != 4'b0100);
        return d;
    endfunction

    // A used source that names a nonzero register equal to the producer target.
    function automatic logic src_hit(input logic used, input logic [4:0] src,
                                     input logic [4:0] tgt);
        return used && (src != 5'd0) && (src == tgt);
    endfunction

    dec_t             dec_d, dec_e, dec_m;
    logic [4:0]       rs_d, rt_d;
    logic             rs_used, rt_used;
    logic [4:0]       dest_e;
    logic             branch_d;
    logic             stall_load_use, stall_br_alu, stall_br_load, stall_mdu;
    logic             stall;
    logic             md_start;
    logic             md_busy;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_d    = decode(bus.IR_D);
        dec_e    = decode(bus.IR_E);
        dec_m    = decode(bus.IR_M);
        rs_d     = bus.IR_D[25:21];
        rt_d     = bus.IR_D[20:16];

        rs_used  = dec_d.beq | dec_d.jr | dec_d.cal_r | dec_d.cal_i |
                   dec_d.ld  | dec_d.st | dec_d.md_st | dec_d.md_wr;
        rt_used  = dec_d.beq | dec_d.cal_r | dec_d.st | dec_d.md_st;
        branch_d = dec_d.beq | dec_d.jr;

        // Register 0 as destination means "no result", so it never matches.
        dest_e = 5'd0;
        if (dec_e.cal_r || dec_e.md_rd) begin
            dest_e = bus.IR_E[15:11];
        end else if (dec_e.cal_i) begin
            dest_e = bus.IR_E[20:16];
        end

        md_start = dec_e.md_st;
        md_busy  = (cnt_q != '0);

        stall_load_use = dec_e.ld &&
                         (src_hit(rs_used, rs_d, bus.IR_E[20:16]) ||
                          src_hit(rt_used, rt_d, bus.IR_E[20:16]));
        stall_br_alu   = branch_d &&
                         (src_hit(rs_used, rs_d, dest_e) ||
                          src_hit(rt_used, rt_d, dest_e));
        stall_br_load  = branch_d && dec_m.ld &&
                         (src_hit(rs_used, rs_d, bus.IR_M[20:16]) ||
                          src_hit(rt_used, rt_d, bus.IR_M[20:16]));
        // md_start covers the cycle before the countdown is loaded.
        stall_mdu      = (dec_d.md_st | dec_d.md_rd | dec_d.md_wr) &&
                         (md_start || md_busy);

        stall = stall_load_use | stall_br_alu | stall_br_load | stall_mdu;

        cnt_d = cnt_q;
        if (md_start) begin
            cnt_d = bus.IR_E[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.flush_E      = stall;
    assign bus.md_start     = md_start;
    assign bus.md_op        = bus.IR_E[1:0];
    assign bus.md_busy      = md_busy;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Hazard controller for the 5-stage MIPS pipeline; sits beside the bypass-select unit.
- Decides when forwarding cannot cover a dependency and freezes PC and IF/ID, injecting a bubble into ID/EX.
- Sequences the multi-cycle multiply/divide unit (MDU): start pulse, opcode, busy countdown.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15).
- DIV_CYCLES, 10, busy cycles after a div/divu start (1..15).
- CNT_W, 4, width of the MDU countdown register; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- IR_D  in  32  instruction in ID.
- IR_E  in  32  instruction in EX.
- IR_M  in  32  instruction in MEM.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_E  out  1  load NOP (32'b0) into ID/EX this cycle.
- md_start  out  1  one-cycle start pulse to the MDU.
- md_op  out  2  MDU operation: 0 mult, 1 multu, 2 div, 3 divu; valid with md_start.
- md_busy  out  1  MDU countdown nonzero.
- stall_cycles  out  32  count of stalled cycles since reset, saturating.

Behaviour:
- Decode (op = IR[31:26], func = IR[5:0]):
  - ld: op 100011. st: op 101011. beq: op 000100. jr: op 0, func 001000.
  - cal_i: op 001101 or 001111; writes rt.
  - md_start class: op 0, func 011000..011011.
  - md_rd class: op 0, func 010000 or 010010 (mfhi/mflo); writes rd.
  - md_wr class: op 0, func 010001 or 010011 (mthi/mtlo); reads rs only.
  - cal_r: op 0, func not in {0, jr, the md funcs}; writes rd. mfhi/mflo are also rd writers for hazard checks.
- Source use in D:
  - rs used by beq, jr, cal_r, cal_i, ld, st, md_start, md_wr.
  - rt used by beq, cal_r, st, md_start.
- A match on register 0 never counts.
- Stall conditions; stall is the OR of all of them:
  - Load-use: ld in E, IR_E.rt != 0, and a used D source equals IR_E.rt.
  - Branch-on-ALU: beq or jr in D, and a used source equals the destination of cal_r, md_rd or cal_i in E.
  - Branch-on-load: beq or jr in D, and a used source equals IR_M.rt while ld is in M.
  - MDU: any md class (start, rd or wr) in D while md_start=1 or md_busy=1.
- flush_E equals stall. Both are combinational from the current IR values and state, with no added latency.
- MDU sequencing:
  - md_start is combinational: an md_start-class instruction is in IR_E.
  - md_op = func[1:0] of IR_E.
  - On the clock edge with md_start=1, cnt loads MULT_CYCLES (func[1]=0) or DIV_CYCLES (func[1]=1).
  - Otherwise cnt decrements when nonzero.
  - md_busy = (cnt != 0), registered.
  - A second md instruction is held in D, so md_start with md_busy=1 cannot occur. Flag it as a bench assertion.
- Stall release: the cycle cnt reads 0 with no md_start, a stalled md instruction in D proceeds.
- Total stall for mult followed immediately by mfhi: 1 (start cycle) + MULT_CYCLES cycles.
- stall_cycles increments on each clock edge where stall=1 and holds at 32'hFFFFFFFF.
- Reset, including mid-countdown, on the next edge:
  - cnt=0, md_busy=0, stall_cycles=0.
  - stall, flush_E and md_start then follow the IR inputs only.
- Simultaneous conditions (e.g. load-use plus MDU) yield a single stall. The counter still increments by exactly 1 per cycle.

Test Plan:
- Load-use: IR_E=lw $8,0($0); IR_D=addu $9,$8,$1 -> stall=flush_E=1 for 1 cycle; stall_cycles 0->1. With IR_D using $0 instead -> no stall.
- Branch-on-ALU: IR_E=ori $5,$0,1; IR_D=beq $5,$6 -> stall=1. Same with IR_E=lui $0 -> stall=0.
- Branch-on-load: IR_M=lw $31; IR_D=jr $31 -> stall=1 for 1 cycle; IR_E=NOP -> stall=0.
- MDU mult+mfhi (MULT_CYCLES=5): mult in E, mfhi in D -> md_start=1 and md_op=0 for one cycle; md_busy=1 for exactly 5 cycles; stall=1 for 6 cycles, then 0; stall_cycles=6.
- Divu then mtlo (DIV_CYCLES=10): md_op=3, md_busy high 10 cycles. Assert reset at busy cycle 4 -> next edge md_busy=0, stall_cycles=0, stall=0 with mtlo in D.
- Saturation: force stall continuously from stall_cycles=32'hFFFFFFFE -> reads FFFFFFFF and holds.
